// File: rtl/vram_arbiter.sv
// Video RAM arbiter: fixed-latency VGA fetches take priority over a CPU port,
// and a starvation limit can force a CPU slot at the cost of one VGA fetch.
module vram_arbiter #(
  parameter int unsigned AW           = 15,
  parameter int unsigned DW           = 8,
  parameter int unsigned STARVE_LIMIT = 64,
  parameter int unsigned WCNT_W       = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              vga_req,
  input  logic [AW-1:0]     vga_addr,
  output logic              vga_rvalid,
  output logic [DW-1:0]     vga_rdata,
  output logic              vga_underrun,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [AW-1:0]     cpu_addr,
  input  logic [DW-1:0]     cpu_wdata,
  output logic              cpu_ack,
  output logic [DW-1:0]     cpu_rdata,
  output logic              cpu_starved,
  output logic [WCNT_W-1:0] cpu_wait_max,
  output logic              ram_en,
  output logic              ram_we,
  output logic [AW-1:0]     ram_addr,
  output logic [DW-1:0]     ram_wdata,
  input  logic [DW-1:0]     ram_rdata
);

  localparam logic [2:0] C_IDLE  = 3'd0;
  localparam logic [2:0] C_WAIT  = 3'd1;
  localparam logic [2:0] C_RD    = 3'd2;
  localparam logic [2:0] C_RDRET = 3'd3;
  localparam logic [2:0] C_ACK   = 3'd4;

  localparam logic              FORCE_EN = (STARVE_LIMIT != 0);
  localparam logic [WCNT_W-1:0] WCNT_MAX = '1;
  localparam logic [WCNT_W-1:0] WCNT_LIM = WCNT_W'(STARVE_LIMIT);

  logic [2:0]        state;
  logic [2:0]        state_nxt;
  logic [WCNT_W-1:0] wcnt;
  logic [1:0]        vga_pend;
  logic [1:0]        drop_pend;

  logic cpu_free_c;
  logic force_c;
  logic cpu_grant_c;
  logic vga_win_c;
  logic vga_drop_c;

  // Slot decision for the current cycle.
  always_comb begin
    cpu_free_c  = (state == C_IDLE) || (state == C_WAIT);
    force_c     = FORCE_EN && (state == C_WAIT) && (wcnt == WCNT_LIM);
    cpu_grant_c = cpu_req && cpu_free_c && (!vga_req || force_c);
    vga_win_c   = vga_req && !cpu_grant_c;
    vga_drop_c  = vga_req && cpu_grant_c;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= C_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      C_IDLE, C_WAIT: begin
        if (cpu_grant_c) begin
          state_nxt = cpu_we ? C_ACK : C_RD;
        end else begin
          state_nxt = cpu_req ? C_WAIT : C_IDLE;
        end
      end
      C_RD:    state_nxt = C_RDRET;
      C_RDRET: state_nxt = C_ACK;
      C_ACK:   state_nxt = C_IDLE;
      default: state_nxt = C_IDLE;
    endcase
  end

  // Memory issue, read-return pipelines and CPU bookkeeping.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ram_en       <= 1'b0;
      ram_we       <= 1'b0;
      ram_addr     <= '0;
      ram_wdata    <= '0;
      vga_pend     <= '0;
      drop_pend    <= '0;
      vga_rvalid   <= 1'b0;
      vga_rdata    <= '0;
      vga_underrun <= 1'b0;
      cpu_ack      <= 1'b0;
      cpu_rdata    <= '0;
      cpu_starved  <= 1'b0;
      cpu_wait_max <= '0;
      wcnt         <= '0;
    end else begin
      ram_en <= vga_win_c || cpu_grant_c;
      ram_we <= cpu_grant_c && cpu_we;
      if (cpu_grant_c) begin
        ram_addr  <= cpu_addr;
        ram_wdata <= cpu_wdata;
      end else if (vga_win_c) begin
        ram_addr <= vga_addr;
      end

      vga_pend     <= {vga_pend[0], vga_win_c};
      drop_pend    <= {drop_pend[0], vga_drop_c};
      vga_rvalid   <= vga_pend[1];
      vga_underrun <= drop_pend[1];
      if (vga_pend[1]) begin
        vga_rdata <= ram_rdata;
      end

      cpu_ack <= (state_nxt == C_ACK);
      if (state == C_RDRET) begin
        cpu_rdata <= ram_rdata;
      end

      // Wait counter counts every ungranted request cycle, saturating.
      if (cpu_grant_c) begin
        wcnt <= '0;
        if ((state == C_WAIT) && (wcnt > cpu_wait_max)) begin
          cpu_wait_max <= wcnt;
        end
        if (force_c) begin
          cpu_starved <= 1'b1;
        end
      end else if ((state == C_IDLE) && cpu_req) begin
        wcnt <= WCNT_W'(1);
      end else if ((state == C_WAIT) && cpu_req) begin
        if (wcnt != WCNT_MAX) begin
          wcnt <= wcnt + 1'b1;
        end
      end else begin
        wcnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_vram_arbiter.sv
// Bench for vram_arbiter: two instances (starve limit 64 and 0) share stimulus
// and are compared every cycle against an event-schedule model of the arbiter.
module tb_vram_arbiter;

  localparam int unsigned AW = 15;
  localparam int unsigned DW = 8;
  localparam int NC = 2048;

  typedef struct packed {
    logic          vrv;
    logic [DW-1:0] vrd;
    logic          und;
    logic          ack;
    logic [DW-1:0] crd;
    logic          stv;
    logic [7:0]    wmx;
    logic          en;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wd;
  } obs_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic          vga_req = 1'b0;
  logic [AW-1:0] vga_addr = '0;
  logic          cpu_req = 1'b0;
  logic          cpu_we = 1'b0;
  logic [AW-1:0] cpu_addr = '0;
  logic [DW-1:0] cpu_wdata = '0;

  logic          d0_vga_rvalid, d1_vga_rvalid;
  logic [DW-1:0] d0_vga_rdata, d1_vga_rdata;
  logic          d0_vga_underrun, d1_vga_underrun;
  logic          d0_cpu_ack, d1_cpu_ack;
  logic [DW-1:0] d0_cpu_rdata, d1_cpu_rdata;
  logic          d0_cpu_starved, d1_cpu_starved;
  logic [7:0]    d0_cpu_wait_max, d1_cpu_wait_max;
  logic          d0_ram_en, d1_ram_en, d0_ram_we, d1_ram_we;
  logic [AW-1:0] d0_ram_addr, d1_ram_addr;
  logic [DW-1:0] d0_ram_wdata, d1_ram_wdata, d0_ram_rdata, d1_ram_rdata;

  logic [DW-1:0] mem0 [32768];
  logic [DW-1:0] mem1 [32768];

  // Reference model state: per-instance event schedule indexed by cycle.
  bit          ev_v  [2][NC];
  bit [DW-1:0] ev_d  [2][NC];
  bit          e_und [2][NC];
  bit          e_ack [2][NC];
  bit          e_rd  [2][NC];
  bit [DW-1:0] e_crd [2][NC];
  bit          e_en  [2][NC];
  bit          e_we  [2][NC];
  bit [AW-1:0] e_addr[2][NC];
  bit [DW-1:0] e_wd  [2][NC];
  bit [DW-1:0] mm    [2][32768];
  int          n[2];
  int          ack_c[2];
  int          wmax[2];
  bit          starved[2];
  bit [DW-1:0] last_vd[2];
  bit [DW-1:0] last_crd[2];
  int          und_cnt[2];
  int          ack_cnt[2];

  int cyc = 0;
  int checks = 0;
  int errors = 0;

  vram_arbiter #(.AW(AW), .DW(DW), .STARVE_LIMIT(64), .WCNT_W(8)) dut64 (
    .clk(clk), .reset(reset),
    .vga_req(vga_req), .vga_addr(vga_addr),
    .vga_rvalid(d0_vga_rvalid), .vga_rdata(d0_vga_rdata), .vga_underrun(d0_vga_underrun),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(d0_cpu_ack), .cpu_rdata(d0_cpu_rdata), .cpu_starved(d0_cpu_starved),
    .cpu_wait_max(d0_cpu_wait_max),
    .ram_en(d0_ram_en), .ram_we(d0_ram_we), .ram_addr(d0_ram_addr),
    .ram_wdata(d0_ram_wdata), .ram_rdata(d0_ram_rdata)
  );

  vram_arbiter #(.AW(AW), .DW(DW), .STARVE_LIMIT(0), .WCNT_W(8)) dut0 (
    .clk(clk), .reset(reset),
    .vga_req(vga_req), .vga_addr(vga_addr),
    .vga_rvalid(d1_vga_rvalid), .vga_rdata(d1_vga_rdata), .vga_underrun(d1_vga_underrun),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(d1_cpu_ack), .cpu_rdata(d1_cpu_rdata), .cpu_starved(d1_cpu_starved),
    .cpu_wait_max(d1_cpu_wait_max),
    .ram_en(d1_ram_en), .ram_we(d1_ram_we), .ram_addr(d1_ram_addr),
    .ram_wdata(d1_ram_wdata), .ram_rdata(d1_ram_rdata)
  );

  always #5 clk = ~clk;

  // Synchronous-read video RAMs, one per instance.
  always @(posedge clk) begin
    if (d0_ram_en) begin
      if (d0_ram_we) mem0[d0_ram_addr] <= d0_ram_wdata;
      else d0_ram_rdata <= mem0[d0_ram_addr];
    end
  end

  always @(posedge clk) begin
    if (d1_ram_en) begin
      if (d1_ram_we) mem1[d1_ram_addr] <= d1_ram_wdata;
      else d1_ram_rdata <= mem1[d1_ram_addr];
    end
  end

  function automatic obs_t sample(int i);
    obs_t o;
    if (i == 0) begin
      o.vrv = d0_vga_rvalid; o.vrd = d0_vga_rdata; o.und = d0_vga_underrun;
      o.ack = d0_cpu_ack; o.crd = d0_cpu_rdata; o.stv = d0_cpu_starved;
      o.wmx = d0_cpu_wait_max; o.en = d0_ram_en; o.we = d0_ram_we;
      o.addr = d0_ram_addr; o.wd = d0_ram_wdata;
    end else begin
      o.vrv = d1_vga_rvalid; o.vrd = d1_vga_rdata; o.und = d1_vga_underrun;
      o.ack = d1_cpu_ack; o.crd = d1_cpu_rdata; o.stv = d1_cpu_starved;
      o.wmx = d1_cpu_wait_max; o.en = d1_ram_en; o.we = d1_ram_we;
      o.addr = d1_ram_addr; o.wd = d1_ram_wdata;
    end
    return o;
  endfunction

  task automatic chk(string tag, int i, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s dut%0d cyc=%0d observed=%0h expected=%0h", tag, i, cyc, obs, exp);
    end
  endtask

  function automatic bit any_waiting();
    return (n[0] > 0) || (n[1] > 0);
  endfunction

  // Apply the arbitration rules to the inputs of cycle t and schedule results.
  task automatic step(int i, int t);
    int lim;
    int cnt;
    bit free_slot;
    bit frc;
    bit grant;
    lim = (i == 0) ? 64 : 0;
    free_slot = (t > ack_c[i]);
    cnt = (n[i] > 255) ? 255 : n[i];
    frc = (lim != 0) && (n[i] > 0) && (cnt == lim);
    grant = cpu_req && free_slot && (!vga_req || frc);
    if (vga_req && !grant) begin
      e_en[i][t+1] = 1'b1;
      e_we[i][t+1] = 1'b0;
      e_addr[i][t+1] = vga_addr;
      ev_v[i][t+3] = 1'b1;
      ev_d[i][t+3] = mm[i][vga_addr];
    end
    if (vga_req && grant) e_und[i][t+3] = 1'b1;
    if (grant) begin
      if (cnt > wmax[i]) wmax[i] = cnt;
      if (frc) starved[i] = 1'b1;
      n[i] = 0;
      e_en[i][t+1] = 1'b1;
      e_we[i][t+1] = cpu_we;
      e_addr[i][t+1] = cpu_addr;
      e_wd[i][t+1] = cpu_wdata;
      if (cpu_we) begin
        mm[i][cpu_addr] = cpu_wdata;
        e_ack[i][t+1] = 1'b1;
        ack_c[i] = t + 1;
      end else begin
        e_ack[i][t+3] = 1'b1;
        e_rd[i][t+3] = 1'b1;
        e_crd[i][t+3] = mm[i][cpu_addr];
        ack_c[i] = t + 3;
      end
    end else if (cpu_req && free_slot) begin
      n[i]++;
    end else begin
      n[i] = 0;
    end
  endtask

  task automatic check_all(int c);
    for (int i = 0; i < 2; i++) begin
      obs_t o;
      o = sample(i);
      if (ev_v[i][c]) last_vd[i] = ev_d[i][c];
      if (e_rd[i][c]) last_crd[i] = e_crd[i][c];
      if (o.und === 1'b1) und_cnt[i]++;
      if (o.ack === 1'b1) ack_cnt[i]++;
      chk("vga_rvalid", i, 32'(o.vrv), 32'(ev_v[i][c]));
      chk("vga_rdata", i, 32'(o.vrd), 32'(last_vd[i]));
      chk("vga_underrun", i, 32'(o.und), 32'(e_und[i][c]));
      chk("cpu_ack", i, 32'(o.ack), 32'(e_ack[i][c]));
      chk("cpu_rdata", i, 32'(o.crd), 32'(last_crd[i]));
      chk("cpu_starved", i, 32'(o.stv), 32'(starved[i]));
      chk("cpu_wait_max", i, 32'(o.wmx), 32'(wmax[i]));
      chk("ram_en", i, 32'(o.en), 32'(e_en[i][c]));
      if (e_en[i][c]) begin
        chk("ram_we", i, 32'(o.we), 32'(e_we[i][c]));
        chk("ram_addr", i, 32'(o.addr), 32'(e_addr[i][c]));
        if (e_we[i][c]) chk("ram_wdata", i, 32'(o.wd), 32'(e_wd[i][c]));
      end
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    if (reset) begin
      step(0, cyc);
      step(1, cyc);
    end
    @(negedge clk);
    check_all(cyc + 1);
    cyc++;
  endtask

  task automatic check_zero(string tag);
    for (int i = 0; i < 2; i++) begin
      obs_t o;
      o = sample(i);
      chk({tag, "_outputs"}, i, 32'(o), 32'(0));
    end
  endtask

  task automatic clear_model(int from);
    for (int i = 0; i < 2; i++) begin
      for (int c = from; c < NC; c++) begin
        ev_v[i][c] = 0; e_und[i][c] = 0; e_ack[i][c] = 0;
        e_rd[i][c] = 0; e_en[i][c] = 0; e_we[i][c] = 0;
      end
      n[i] = 0; ack_c[i] = -1; wmax[i] = 0; starved[i] = 0;
      last_vd[i] = '0; last_crd[i] = '0;
    end
  endtask

  task automatic do_reset();
    #1 reset = 1'b0;
    #1 check_zero("async_reset");
    clear_model(cyc);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    cyc++;
  endtask

  task automatic cpu_op(logic we, logic [AW-1:0] a, logic [DW-1:0] d);
    cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = d;
    cycle();
    for (int g = 0; g < 500 && any_waiting(); g++) cycle();
    cpu_req = 1'b0;
    repeat (4) cycle();
  endtask

  initial begin
    for (int a = 0; a < 32768; a++) begin
      mem0[a] = DW'(a);
      mem1[a] = DW'(a);
      mm[0][a] = DW'(a);
      mm[1][a] = DW'(a);
    end
    clear_model(0);
    und_cnt = '{0, 0};
    ack_cnt = '{0, 0};

    @(negedge clk);
    check_zero("reset");
    reset = 1'b1;

    // Back-to-back VGA fetches of 0..3.
    for (int k = 0; k < 4; k++) begin
      vga_req = 1'b1;
      vga_addr = AW'(k);
      cycle();
    end
    vga_req = 1'b0;
    repeat (5) cycle();

    // CPU write then read-back on an idle bus.
    cpu_op(1'b1, 15'h1234, 8'hA5);
    cpu_op(1'b0, 15'h1234, 8'h00);
    chk("readback_a5", 0, 32'(d0_cpu_rdata), 32'h0000_00A5);
    chk("readback_a5", 1, 32'(d1_cpu_rdata), 32'h0000_00A5);

    // VGA saturates the bus for 70 cycles while a CPU write is pending.
    und_cnt = '{0, 0};
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 15'h0100; cpu_wdata = 8'h5A;
    for (int k = 0; k < 70; k++) begin
      vga_req = 1'b1;
      vga_addr = AW'(16'h0200 + k);
      cycle();
      if (!any_waiting()) cpu_req = 1'b0;
    end
    vga_req = 1'b0;
    cycle();
    if (!any_waiting()) cpu_req = 1'b0;
    repeat (6) cycle();
    chk("starve_underruns", 0, 32'(und_cnt[0]), 32'd1);
    chk("starve_underruns", 1, 32'(und_cnt[1]), 32'd0);
    chk("starve_flag", 0, 32'(d0_cpu_starved), 32'd1);
    chk("starve_flag", 1, 32'(d1_cpu_starved), 32'd0);
    chk("starve_wait_max", 0, 32'(d0_cpu_wait_max), 32'd64);
    chk("starve_wait_max", 1, 32'(d1_cpu_wait_max), 32'd70);

    // Async reset one cycle after a CPU read grant.
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 15'h0042;
    cycle();
    cpu_req = 1'b0;
    do_reset();
    ack_cnt = '{0, 0};
    repeat (8) cycle();
    for (int i = 0; i < 2; i++) begin
      obs_t o;
      o = sample(i);
      chk("post_reset_acks", i, 32'(ack_cnt[i]), 32'd0);
      chk("post_reset_starved", i, 32'(o.stv), 32'd0);
      chk("post_reset_wait_max", i, 32'(o.wmx), 32'd0);
    end

    // Long saturation: the unforced wait counter must clamp at 255.
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 15'h0007; cpu_wdata = 8'hC3;
    for (int k = 0; k < 300; k++) begin
      vga_req = 1'b1;
      vga_addr = AW'($urandom_range(0, 63));
      cycle();
      if (!any_waiting()) cpu_req = 1'b0;
    end
    vga_req = 1'b0;
    cycle();
    if (!any_waiting()) cpu_req = 1'b0;
    repeat (6) cycle();
    chk("sat_wait_max", 0, 32'(d0_cpu_wait_max), 32'd64);
    chk("sat_wait_max", 1, 32'(d1_cpu_wait_max), 32'd255);

    // Random traffic; CPU inputs only change while no request is waiting.
    for (int k = 0; k < 600; k++) begin
      vga_req = ($urandom_range(0, 9) < 6);
      vga_addr = AW'($urandom_range(0, 63));
      if (!any_waiting()) begin
        cpu_req = 1'($urandom_range(0, 1));
        cpu_we = 1'($urandom_range(0, 1));
        cpu_addr = AW'($urandom_range(0, 63));
        cpu_wdata = DW'($urandom);
      end
      cycle();
    end
    vga_req = 1'b0;
    for (int g = 0; g < 500 && any_waiting(); g++) cycle();
    cpu_req = 1'b0;
    repeat (6) cycle();

    // cpu_req held through ack with a fresh address each transaction.
    cpu_req = 1'b1;
    for (int k = 0; k < 20; k++) begin
      if (!any_waiting()) begin
        cpu_we = 1'($urandom_range(0, 1));
        cpu_addr = AW'(16'h0300 + k);
        cpu_wdata = DW'($urandom);
      end
      vga_req = (k % 5 == 2);
      vga_addr = AW'(k);
      cycle();
    end
    vga_req = 1'b0;
    for (int g = 0; g < 500 && any_waiting(); g++) cycle();
    cpu_req = 1'b0;
    repeat (6) cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
